// File: rtl/stdout_pkg.sv
// stdout_pkg
//   Shared definitions for the stdout byte buffer: the drain FSM state
//   encoding and the default buffer address width (depth = 2**width bytes).
package stdout_pkg;

  localparam int STDOUT_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    GUARD = 3'd3,
    DRAIN = 3'd4
  } drain_state_t;

endpackage

// File: rtl/stdout_ram.sv
// stdout_ram
//   Simple dual-port block RAM, 8 bits wide, no reset.
//   Ports:
//     clk      - clock
//     wr_en    - write strobe
//     wr_addr  - write address
//     wr_data  - write byte
//     rd_en    - read strobe; rd_data updates one cycle later
//     rd_addr  - read address
//     rd_data  - registered read data, holds between reads
module stdout_ram
  import stdout_pkg::*;
#(
  parameter int ADDR_WIDTH = STDOUT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  (* ram_style = "block" *) logic [7:0] mem_r [0:(2**ADDR_WIDTH)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/stdout_buffer.sv
// stdout_buffer
//   Byte FIFO between the CPU output path and the UART transmitter. The CPU
//   pushes at most one byte per cycle; a drain FSM pops bytes in order and
//   hands each to the transmitter with a tx_start pulse, then waits for
//   tx_busy to drop before looking for the next byte.
//   Optional feature macro: STDOUT_DROP_COUNT_EN adds a saturating 16-bit
//   counter (drop_count) of pushes attempted while full.
//   Ports:
//     clk          - single clock
//     reset        - asynchronous, active-high reset
//     write_enable - CPU push strobe
//     write_data   - byte to push
//     write_ready  - high when not full; pushes while low are discarded
//     empty        - high when count == 0
//     count        - bytes buffered and not yet handed to the transmitter
//     tx_start     - one-cycle pulse, tx_data valid in that cycle
//     tx_data      - byte for the transmitter, held until next tx_start
//     tx_busy      - transmitter is shifting a byte
//     drop_count   - dropped-push counter (STDOUT_DROP_COUNT_EN only)
module stdout_buffer
  import stdout_pkg::*;
#(
  parameter int ADDR_WIDTH = STDOUT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [7:0]            write_data,
  output logic                  write_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
`ifdef STDOUT_DROP_COUNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] rptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic                  empty_r;
  logic                  write_ready_r;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  drain_state_t          state_r;
  drain_state_t          state_s;
  logic                  ram_rd_en_s;
  logic [7:0]            ram_rdata_s;
  logic                  tx_start_r;
  logic [7:0]            tx_data_r;

  // count is the only full/empty source; pointers wrap naturally.
  assign full_s = (count_r == DEPTH_C);
  assign push_s = write_enable && !full_s;
  assign pop_s  = (state_r == SEND);

  stdout_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wptr_r),
    .wr_data (write_data),
    .rd_en   (ram_rd_en_s),
    .rd_addr (rptr_r),
    .rd_data (ram_rdata_s)
  );

  // Next occupancy: a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE_C;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE_C;
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO pointers, occupancy and the flags derived from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r        <= {ADDR_WIDTH{1'b0}};
      rptr_r        <= {ADDR_WIDTH{1'b0}};
      count_r       <= {(ADDR_WIDTH+1){1'b0}};
      empty_r       <= 1'b1;
      write_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE_C;
      end
      count_r       <= count_next_s;
      empty_r       <= (count_next_s == {(ADDR_WIDTH+1){1'b0}});
      write_ready_r <= (count_next_s != DEPTH_C);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Drain FSM next state; FETCH issues the RAM read so data lands in SEND.
  always_comb begin
    state_s     = state_r;
    ram_rd_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_r) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        ram_rd_en_s = 1'b1;
        state_s     = SEND;
      end
      SEND: begin
        state_s = GUARD;
      end
      GUARD: begin
        // Gives the transmitter a cycle to raise tx_busy.
        state_s = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Transmit handshake: tx_start is high exactly during SEND, and the popped
  // byte is captured at the end of SEND so tx_data holds it afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      tx_start_r <= (state_s == SEND);
      if (pop_s) begin
        tx_data_r <= ram_rdata_s;
      end
    end
  end

  // During SEND the RAM read register already holds the byte, so it is shown
  // directly; tx_data therefore is valid in the same cycle as tx_start.
  assign tx_data     = pop_s ? ram_rdata_s : tx_data_r;
  assign tx_start    = tx_start_r;
  assign count       = count_r;
  assign empty       = empty_r;
  assign write_ready = write_ready_r;

`ifdef STDOUT_DROP_COUNT_EN
  logic [15:0] drop_count_r;

  // Saturating count of pushes attempted while full; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_r <= 16'h0000;
    end else if (write_enable && full_s && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'd1;
    end
  end

  assign drop_count = drop_count_r;
`endif

endmodule
